xor_frame_checksum: RTL
=======================

Name: xor_frame_checksum

Overview:
Parametrised, sequential successor to the single-bit XOR gate. It accepts a stream of WIDTH-bit words over a valid/ready handshake and accumulates their bitwise XOR across a frame delimited by in_last. It then presents the checksum, a reduction-parity bit and the word count on a valid/ready output port. It sits between a word source and a checker/consumer and is the first stateful block in the XOR family.

Parameters:
WIDTH, 8, data word width in bits (>=1)
MAX_LEN, 16, maximum words per frame; frame force-closed on reaching it (>=1)
ODD, 0, 0 = out_parity is even parity of out_sum; 1 = inverted (odd parity)

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  in_data/in_last valid this cycle
in_ready  output  1  block can accept a word this cycle
in_data  input  WIDTH  data word
in_last  input  1  marks final word of frame
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
out_sum  output  WIDTH  XOR of all words in frame
out_parity  output  1  (^out_sum) ^ ODD
out_count  output  CW=$clog2(MAX_LEN+1)  words in frame
out_overflow  output  1  frame closed by MAX_LEN, not by in_last

Behaviour:
- Reset (async assert, sync release to clk): state=ACCUM, acc=0, count=0, ovf=0; outputs: in_ready=1, out_valid=0, out_sum=0, out_count=0, out_overflow=0, out_parity=ODD.
- States: ACCUM, HOLD. in_ready = (state==ACCUM); out_valid = (state==HOLD). Both registered-state decodes; no combinational path from out_ready to in_ready.
- Input beat = in_valid & in_ready. Without a beat, no state change (gaps allowed; in_data/in_last ignored).
- ACCUM on beat: acc <= acc ^ in_data; count <= count+1.
  - in_last=1 -> HOLD, ovf<=0.
  - in_last=0 and count+1==MAX_LEN -> HOLD, ovf<=1.
  - in_last=1 on the MAX_LEN-th word -> ovf=0 (in_last has priority).
  - else stay ACCUM.
- Latency: result visible the cycle after the last beat is accepted (1 cycle).
- HOLD: out_sum=acc, out_count=count, out_overflow=ovf, all stable while out_valid=1 and out_ready=0. in_ready=0; words presented are not consumed.
- HOLD with out_ready=1: next cycle state=ACCUM, acc=0, count=0, ovf=0. The next frame's first beat can occur that cycle (one bubble per frame).
- out_parity combinational from out_sum; in ACCUM out_sum/out_count show 0 (gated), not the partial acc.
- count never exceeds MAX_LEN; no wrap.
- Reset mid-frame or in HOLD discards partial or pending result; no output handshake occurs.
- MAX_LEN=1: every beat closes the frame; ovf=1 unless in_last=1.

Test Plan (WIDTH=8, MAX_LEN=4, ODD=0 unless stated):
1. Assert rst mid-cycle, no clk edge -> outputs drop immediately to in_ready=1, out_valid=0, out_sum=0x00, out_count=0, out_parity=0.
2. Beats 0x0F, 0xF0, 0x55(last), out_ready=1 -> next cycle out_valid=1, out_sum=0xAA, out_count=3, out_parity=0, out_overflow=0. One cycle later in_ready=1.
3. Frame 0x80(last), out_ready=0 for 3 cycles, in_valid=1 throughout with 0x11 -> out_valid held, out_sum=0x80, out_parity=1, in_ready=0. After out_ready=1, next frame 0x11(last) -> out_sum=0x11, count=1 (stale word not double-counted).
4. Beats 0x01, 0x02, 0x04, 0x08, none last -> out_valid after 4th; out_sum=0x0F, out_count=4, out_overflow=1, out_parity=0. Repeat with 4th word in_last=1 -> out_overflow=0.
5. Two beats 0x12, 0x34, rst pulse, then 0x33(last) -> out_sum=0x33, out_count=1. Result for 0x12/0x34 never appears.
6. ODD=1, frame 0x80(last) with 2 idle in_valid=0 cycles before it -> out_parity=0, out_count=1.

Source files
------------

// File: rtl/xor_frame_checksum.sv
// xor_frame_checksum
// ------------------
// Accumulates the bitwise XOR of a stream of WIDTH-bit words over a frame
// and presents checksum, parity and word count as a single result.
// The frame is closed by in_last, or forcibly when MAX_LEN words have been
// accepted without in_last.
//
// Handshake semantics (both ports): a transfer happens on a rising clk edge
// where valid and ready are both 1. A producer holds its payload stable while
// valid=1 and ready=0. Neither ready depends combinationally on the other
// port; both readys/valids are decodes of the registered state.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   in_valid     in_data/in_last are valid
//   in_ready     block accepts a word (ACCUM state)
//   in_data      data word
//   in_last      final word of frame
//   out_valid    result available (HOLD state)
//   out_ready    consumer accepts the result
//   out_sum      XOR of all words in the frame (0 while accumulating)
//   out_parity   (^out_sum) ^ ODD
//   out_count    number of words in the frame (0 while accumulating)
//   out_overflow frame was closed by MAX_LEN rather than in_last
//   dbg_state    current FSM state: 0 = ACCUM, 1 = HOLD

module xor_frame_checksum #(
    parameter int WIDTH   = 8,
    parameter int MAX_LEN = 16,
    parameter int ODD     = 0,
    localparam int CW     = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_parity,
    output logic [CW-1:0]    out_count,
    output logic             out_overflow,
    output logic             dbg_state
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LEN);
    localparam logic          ODD_BIT = (ODD != 0);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] acc, acc_nxt;
    logic [CW-1:0]    count, count_nxt;
    logic             ovf, ovf_nxt;
    logic [CW-1:0]    count_inc;
    logic             beat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACCUM;
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            count <= count_nxt;
            ovf   <= ovf_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        acc_nxt      = acc;
        count_nxt    = count;
        ovf_nxt      = ovf;
        in_ready     = (state == ACCUM);
        out_valid    = (state == HOLD);
        beat         = in_valid && (state == ACCUM);
        count_inc    = count + CW'(1);
        // Partial accumulation is hidden until the frame closes.
        out_sum      = (state == HOLD) ? acc   : '0;
        out_count    = (state == HOLD) ? count : '0;
        out_overflow = (state == HOLD) ? ovf   : 1'b0;
        dbg_state    = (state == HOLD);

        case (state)
            ACCUM: begin
                if (beat) begin
                    acc_nxt   = acc ^ in_data;
                    count_nxt = count_inc;
                    // in_last wins over the length limit on the same word.
                    if (in_last) begin
                        state_nxt = HOLD;
                        ovf_nxt   = 1'b0;
                    end else if (count_inc == MAX_CNT) begin
                        state_nxt = HOLD;
                        ovf_nxt   = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nxt = ACCUM;
                    acc_nxt   = '0;
                    count_nxt = '0;
                    ovf_nxt   = 1'b0;
                end
            end
            default: state_nxt = ACCUM;
        endcase

        out_parity = (^out_sum) ^ ODD_BIT;
    end

endmodule
